// File: rtl/mips_pkg.sv
// Shared pipeline constants and bundle types for the pipelined MIPS core.
// The ID/EX, EX/MEM and MEM/WB registers all use these types.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int FUNCT_W = 6;
  localparam int ALUOP_W = 3;

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0]  read_data1;
    logic [DATA_W-1:0]  read_data2;
    logic [DATA_W-1:0]  sign_ex_imm;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [FUNCT_W-1:0] funct;
    logic [DATA_W-1:0]  next_pc;
  } id_ex_data_t;

  localparam int CTRL_W = $bits(id_ex_ctrl_t);
  localparam int DBUS_W = $bits(id_ex_data_t);

endpackage

// File: rtl/id_ex_register_if.sv
// Decode-to-execute bundle: decode-side inputs and the registered copies seen by EX.
// master = decode stage (drives inputs), slave = the ID/EX register.
interface id_ex_register_if;
  import mips_pkg::*;

  logic               hit;
  logic               flush;
  logic [DATA_W-1:0]  readData1;
  logic [DATA_W-1:0]  readData2;
  logic [DATA_W-1:0]  signExImmediate;
  logic               RegDst;
  logic               ALUSrc;
  logic               MemtoReg;
  logic               RegWrite;
  logic               MemRead;
  logic               MemWrite;
  logic               Branch;
  logic [ALUOP_W-1:0] ALUOp;
  logic [REG_W-1:0]   rt;
  logic [REG_W-1:0]   rd;
  logic [FUNCT_W-1:0] funct;
  logic [DATA_W-1:0]  nextPC;

  logic [DATA_W-1:0]  readData1Out;
  logic [DATA_W-1:0]  readData2Out;
  logic [DATA_W-1:0]  signExImmediateOut;
  logic               RegDstOut;
  logic               ALUSrcOut;
  logic               MemtoRegOut;
  logic               RegWriteOut;
  logic               MemReadOut;
  logic               MemWriteOut;
  logic               BranchOut;
  logic [ALUOP_W-1:0] ALUOpOut;
  logic [REG_W-1:0]   rtOut;
  logic [REG_W-1:0]   rdOut;
  logic [FUNCT_W-1:0] functOut;
  logic [DATA_W-1:0]  nextPCOut;
  logic               hitOut;

  modport master (
    output hit, flush, readData1, readData2, signExImmediate,
           RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
           ALUOp, rt, rd, funct, nextPC,
    input  readData1Out, readData2Out, signExImmediateOut,
           RegDstOut, ALUSrcOut, MemtoRegOut, RegWriteOut, MemReadOut,
           MemWriteOut, BranchOut, ALUOpOut, rtOut, rdOut, functOut,
           nextPCOut, hitOut
  );

  modport slave (
    input  hit, flush, readData1, readData2, signExImmediate,
           RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
           ALUOp, rt, rd, funct, nextPC,
    output readData1Out, readData2Out, signExImmediateOut,
           RegDstOut, ALUSrcOut, MemtoRegOut, RegWriteOut, MemReadOut,
           MemWriteOut, BranchOut, ALUOpOut, rtOut, rdOut, functOut,
           nextPCOut, hitOut
  );

endinterface

// File: rtl/pipe_reg_en.sv
// Generic pipeline flop bank: async active-high reset, load enable, synchronous clear.
// Enable has priority over clear, so a held stage keeps its contents.
module pipe_reg_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // NOTE: default to the held value first so every path assigns q_d and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = clr_i ? '0 : d_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: holds on stall (hit=0), bubbles control on flush.
// hitOut always follows hit one cycle later so EX sees the stall.
module id_ex_register
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  id_ex_register_if.slave bus
);

  id_ex_ctrl_t ctrl_d;
  id_ex_ctrl_t ctrl_q;
  id_ex_data_t data_d;
  id_ex_data_t data_q;
  logic        hit_q;

  assign ctrl_d = '{
    reg_dst:    bus.RegDst,
    alu_src:    bus.ALUSrc,
    mem_to_reg: bus.MemtoReg,
    reg_write:  bus.RegWrite,
    mem_read:   bus.MemRead,
    mem_write:  bus.MemWrite,
    branch:     bus.Branch,
    alu_op:     bus.ALUOp
  };

  assign data_d = '{
    read_data1:  bus.readData1,
    read_data2:  bus.readData2,
    sign_ex_imm: bus.signExImmediate,
    rt:          bus.rt,
    rd:          bus.rd,
    funct:       bus.funct,
    next_pc:     bus.nextPC
  };

  pipe_reg_en #(.WIDTH(CTRL_W)) u_ctrl_reg (
    .clk   (clock),
    .rst   (reset),
    .en_i  (bus.hit),
    .clr_i (bus.flush),
    .d_i   (ctrl_d),
    .q_o   (ctrl_q)
  );

  // Operands still advance during a flush; only the control bits become a bubble.
  pipe_reg_en #(.WIDTH(DBUS_W)) u_data_reg (
    .clk   (clock),
    .rst   (reset),
    .en_i  (bus.hit),
    .clr_i (1'b0),
    .d_i   (data_d),
    .q_o   (data_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hit_q <= 1'b0;
    else       hit_q <= bus.hit;
  end

  assign bus.RegDstOut          = ctrl_q.reg_dst;
  assign bus.ALUSrcOut          = ctrl_q.alu_src;
  assign bus.MemtoRegOut        = ctrl_q.mem_to_reg;
  assign bus.RegWriteOut        = ctrl_q.reg_write;
  assign bus.MemReadOut         = ctrl_q.mem_read;
  assign bus.MemWriteOut        = ctrl_q.mem_write;
  assign bus.BranchOut          = ctrl_q.branch;
  assign bus.ALUOpOut           = ctrl_q.alu_op;
  assign bus.readData1Out       = data_q.read_data1;
  assign bus.readData2Out       = data_q.read_data2;
  assign bus.signExImmediateOut = data_q.sign_ex_imm;
  assign bus.rtOut              = data_q.rt;
  assign bus.rdOut              = data_q.rd;
  assign bus.functOut           = data_q.funct;
  assign bus.nextPCOut          = data_q.next_pc;
  assign bus.hitOut             = hit_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: a reference model predicts each edge's
// result into a scoreboard queue, which is popped and compared after the edge.
module tb_id_ex_register;
  import mips_pkg::*;

  typedef struct packed {
    id_ex_ctrl_t ctrl;
    id_ex_data_t data;
    logic        hit;
    logic        flush;
  } stim_t;

  typedef struct packed {
    id_ex_ctrl_t ctrl;
    id_ex_data_t data;
    logic        hit;
  } obs_t;

  logic clock;
  logic reset;
  id_ex_register_if bus ();

  id_ex_register dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    n_compared   = 0;
  int    n_mismatched = 0;
  obs_t  sb[$];
  obs_t  model;
  stim_t cur;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    bus.hit             = s.hit;
    bus.flush           = s.flush;
    bus.RegDst          = s.ctrl.reg_dst;
    bus.ALUSrc          = s.ctrl.alu_src;
    bus.MemtoReg        = s.ctrl.mem_to_reg;
    bus.RegWrite        = s.ctrl.reg_write;
    bus.MemRead         = s.ctrl.mem_read;
    bus.MemWrite        = s.ctrl.mem_write;
    bus.Branch          = s.ctrl.branch;
    bus.ALUOp           = s.ctrl.alu_op;
    bus.readData1       = s.data.read_data1;
    bus.readData2       = s.data.read_data2;
    bus.signExImmediate = s.data.sign_ex_imm;
    bus.rt              = s.data.rt;
    bus.rd              = s.data.rd;
    bus.funct           = s.data.funct;
    bus.nextPC          = s.data.next_pc;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.ctrl.reg_dst     = bus.RegDstOut;
    o.ctrl.alu_src     = bus.ALUSrcOut;
    o.ctrl.mem_to_reg  = bus.MemtoRegOut;
    o.ctrl.reg_write   = bus.RegWriteOut;
    o.ctrl.mem_read    = bus.MemReadOut;
    o.ctrl.mem_write   = bus.MemWriteOut;
    o.ctrl.branch      = bus.BranchOut;
    o.ctrl.alu_op      = bus.ALUOpOut;
    o.data.read_data1  = bus.readData1Out;
    o.data.read_data2  = bus.readData2Out;
    o.data.sign_ex_imm = bus.signExImmediateOut;
    o.data.rt          = bus.rtOut;
    o.data.rd          = bus.rdOut;
    o.data.funct       = bus.functOut;
    o.data.next_pc     = bus.nextPCOut;
    o.hit              = bus.hitOut;
    return o;
  endfunction

  // Reference behaviour of one rising edge with reset low.
  function automatic obs_t predict(input obs_t prev, input stim_t s);
    obs_t n;
    n = prev;
    n.hit = s.hit;
    if (s.hit) begin
      n.data = s.data;
      n.ctrl = s.flush ? id_ex_ctrl_t'('0) : s.ctrl;
    end
    return n;
  endfunction

  task automatic compare_all(input string tag, input obs_t exp);
    obs_t o;
    o = sample();
    check({tag, ".ctrl"}, 160'(o.ctrl), 160'(exp.ctrl));
    check({tag, ".data"}, 160'(o.data), 160'(exp.data));
    check({tag, ".hit"},  160'(o.hit),  160'(exp.hit));
  endtask

  task automatic step(input string tag);
    obs_t exp;
    sb.push_back(predict(model, cur));
    @(posedge clock);
    #1;
    exp = sb.pop_front();
    compare_all(tag, exp);
    model = exp;
  endtask

  function automatic stim_t rand_stim(input logic hit, input logic flush);
    stim_t s;
    s.ctrl             = id_ex_ctrl_t'($urandom_range(0, (1 << CTRL_W) - 1));
    s.data.read_data1  = $urandom;
    s.data.read_data2  = $urandom;
    s.data.sign_ex_imm = $urandom;
    s.data.rt          = REG_W'($urandom);
    s.data.rd          = REG_W'($urandom);
    s.data.funct       = FUNCT_W'($urandom);
    s.data.next_pc     = $urandom;
    s.hit              = hit;
    s.flush            = flush;
    return s;
  endfunction

  initial begin
    reset = 1'b1;
    cur   = '0;
    model = '0;
    drive(cur);
    repeat (2) @(posedge clock);
    #1;
    compare_all("por", obs_t'('0));
    reset = 1'b0;

    // Asynchronous reset with nonzero state and nonzero inputs.
    cur = rand_stim(1'b1, 1'b0);
    cur.data.read_data1 = 32'hDEADBEEF;
    cur.ctrl.reg_write  = 1'b1;
    cur.ctrl.alu_op     = 3'b101;
    drive(cur);
    step("preload");
    #2 reset = 1'b1;
    #1;
    compare_all("rst_async", obs_t'('0));
    model = '0;
    @(posedge clock);
    #1;
    compare_all("rst_hold", obs_t'('0));
    #2 reset = 1'b0;

    // Normal load, with a check that nothing moves before the edge.
    cur = '0;
    cur.hit              = 1'b1;
    cur.data.read_data1  = 32'h12345678;
    cur.data.read_data2  = 32'h9;
    cur.data.sign_ex_imm = 32'hFFFFFFFC;
    cur.data.rt          = 5'd8;
    cur.data.rd          = 5'd16;
    cur.data.funct       = 6'h20;
    cur.data.next_pc     = 32'h4;
    cur.ctrl.reg_dst     = 1'b1;
    cur.ctrl.reg_write   = 1'b1;
    cur.ctrl.alu_op      = 3'b010;
    drive(cur);
    #1;
    compare_all("pre_edge", model);
    step("load");

    // Stall: every input changes, outputs hold, hitOut drops.
    cur = rand_stim(1'b0, 1'b0);
    cur.data.read_data1 = 32'hAAAA0000;
    cur.ctrl.reg_write  = 1'b0;
    drive(cur);
    for (int i = 0; i < 3; i++) step("stall");

    // Flush: control becomes a bubble, operands still load.
    cur = rand_stim(1'b1, 1'b1);
    cur.ctrl.mem_write  = 1'b1;
    cur.ctrl.branch     = 1'b1;
    cur.ctrl.alu_op     = 3'b111;
    cur.data.read_data2 = 32'h55;
    drive(cur);
    step("flush");

    // Load real control, then stall with flush high: nothing may clear.
    cur = rand_stim(1'b1, 1'b0);
    cur.ctrl.reg_write = 1'b1;
    drive(cur);
    step("reload");
    cur = rand_stim(1'b0, 1'b1);
    drive(cur);
    for (int i = 0; i < 2; i++) step("stall_flush");

    // Back-to-back loads interrupted by a short reset pulse.
    for (int i = 0; i < 4; i++) begin
      cur = rand_stim(1'b1, 1'b0);
      drive(cur);
      step("b2b");
    end
    cur = rand_stim(1'b1, 1'b0);
    drive(cur);
    #2 reset = 1'b1;
    #1;
    compare_all("rst_pulse", obs_t'('0));
    model = '0;
    #1 reset = 1'b0;
    step("post_rst");

    // Mixed random traffic.
    for (int i = 0; i < 40; i++) begin
      cur = rand_stim(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
      drive(cur);
      step("rand");
    end

    if (sb.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
